connect_mode_ctrl: RTL and testbench
====================================

# connect_mode_ctrl

Sequencer that owns the compression-path select of the AXI connect fabric between the CNN engine, AIDC and XHB. It tracks outstanding read and write transactions on the XHB side and accepts mode-change requests from configuration. A switch is made only after new address issue is held off and all in-flight traffic has drained. It drives the fabric's `ENABLE` select and a hold signal that upstream logic uses to gate new AR/AW/W valids.

## Interface
- `CNT_W`, 8: width of the outstanding-transaction counters.
- `SETTLE_CYC`, 2: cycles the hold stays asserted after `ENABLE_o` changes. Legal range is 1..15.

- `CLK_i`  in  1  clock; all logic on the rising edge.
- `RSTN_i`  in  1  asynchronous active-low reset.
- `REQ_EN_i`  in  1  requested mode level: 1 = route through AIDC, 0 = bypass.
- `ARVALID_i`, `ARREADY_i`  in  1 each  read address handshake at the XHB side.
- `RVALID_i`, `RREADY_i`, `RLAST_i`  in  1 each  read data handshake and last beat.
- `AWVALID_i`, `AWREADY_i`  in  1 each  write address handshake.
- `WVALID_i`  in  1  write data valid.
- `BVALID_i`, `BREADY_i`  in  1 each  write response handshake.
- `ENABLE_o`  out  1  fabric select; drives the connect fabric `ENABLE` input.
- `HOLD_o`  out  1  upstream must not start new AR/AW/W while this is high.
- `DONE_o`  out  1  one-cycle pulse when a mode switch completes.
- `STATE_o`  out  2  current FSM state: `IDLE`=0, `DRAIN`=1, `SETTLE`=2.
- `RD_OUTST_o`  out  `CNT_W`  outstanding read bursts.
- `WR_OUTST_o`  out  `CNT_W`  outstanding write bursts.
- `ERR_o`  out  1  sticky counter overflow/underflow flag.

## Operation
- **Handshakes:**
  - `arhs` = `ARVALID_i & ARREADY_i`
  - `rhs` = `RVALID_i & RREADY_i & RLAST_i`
  - `awhs` = `AWVALID_i & AWREADY_i`
  - `bhs` = `BVALID_i & BREADY_i`
- **Read counter:** +1 on `arhs`, -1 on `rhs`. If both occur in the same cycle the count is unchanged.
- **Write counter:** +1 on `awhs`, -1 on `bhs`, with the same simultaneous rule.
- **Saturation:**
  - An increment at all-ones holds the value and sets `ERR_o`.
  - A decrement at 0 holds 0 and sets `ERR_o`.
  - `ERR_o` clears only on reset.
- **Counting during hold:** counters keep counting in every state. Handshakes that occur while `HOLD_o`=1 are still counted, so correctness never depends on upstream honouring the hold.
- **`drained`:** `RD_OUTST_o`==0, `WR_OUTST_o`==0, `WVALID_i`=0, and none of `arhs`/`awhs` in the current cycle.
- **FSM:**
  - `IDLE`: if `REQ_EN_i` != `ENABLE_o`, latch target = `REQ_EN_i`, go to `DRAIN`, set `HOLD_o`=1.
  - `DRAIN`: stay until `drained`. Then `ENABLE_o` <= target, load settle counter with `SETTLE_CYC`-1, go to `SETTLE`. There is no timeout.
  - `SETTLE`: decrement the settle counter. At 0, go to `IDLE`, set `HOLD_o`=0, pulse `DONE_o`.
- **`REQ_EN_i` changes outside `IDLE`:** ignored; the latched target is used. If `REQ_EN_i` still differs from `ENABLE_o` on return to `IDLE`, a new sequence starts on the next edge. A request that toggles and returns before being sampled in `IDLE` causes no switch.
- `ENABLE_o` changes only on the `DRAIN`->`SETTLE` transition.

## Timing
- **Reset values:** `ENABLE_o`=0, `HOLD_o`=0, `DONE_o`=0, `STATE_o`=`IDLE`, both counters 0, `ERR_o`=0.
- **Reset assertion:** takes effect immediately, including mid-sequence; `ENABLE_o` drops to 0 without drain.
- **Registered outputs:** all outputs are registered; there is no combinational input-to-output path.
- **Counter update:** counters reflect a handshake on the edge that samples it, i.e. one cycle after the handshake.
- **Best-case switch** (counters 0, no traffic), with the mismatch sampled at edge E:
  - `HOLD_o` rises after E.
  - `ENABLE_o` toggles after E+1.
  - `HOLD_o` falls and `DONE_o` is high after E+1+`SETTLE_CYC`.
  - `HOLD_o` is high for 1+`SETTLE_CYC` cycles.
- **With traffic:** the `DRAIN` dwell extends until the first cycle `drained` is true.
- **`DONE_o`:** high for exactly one cycle per completed switch.

## Test plan
- **Reset:** assert `RSTN_i` low mid-`SETTLE` with `ENABLE_o`=1 -> all outputs at reset values immediately; after release, `REQ_EN_i`=1 restarts a full sequence.
- **Idle switch:** `SETTLE_CYC`=2, no traffic, `REQ_EN_i` 0->1 -> `HOLD_o` high 3 cycles, `ENABLE_o`=1 one edge after `HOLD_o` rises, single `DONE_o` pulse, `STATE_o` sequence 0,1,2,2,0.
- **Drain with traffic:** 3 ARs accepted, then request switch -> `RD_OUTST_o`=3, stay in `DRAIN`. Deliver 3 `RLAST` beats -> `ENABLE_o` toggles the edge after the count reaches 0 with `WVALID_i`=0.
- **Simultaneous events:** `arhs` and `rhs` in the same cycle with `RD_OUTST_o`=1 -> stays 1. `awhs` asserted while `HOLD_o`=1 -> `WR_OUTST_o` increments and the switch waits for its `bhs`.
- **Request bouncing:** `REQ_EN_i` toggled 1->0 during `DRAIN` (target 1) -> `ENABLE_o`=1, `DONE_o`, then an immediate second sequence returning `ENABLE_o` to 0.
- **Saturation:** `CNT_W`=2, 4 ARs with no R -> `RD_OUTST_o`=3, `ERR_o`=1 sticky. With `RD_OUTST_o`=0, a stray `RLAST` handshake -> stays 0 with `ERR_o`=1.

Source files
------------

// File: rtl/connect_mode_ctrl.sv
// connect_mode_ctrl: owns the AIDC/bypass select of the AXI connect fabric.
// It counts outstanding XHB read/write bursts, holds off new address issue
// while a mode change is pending, and flips ENABLE_o only once the fabric is idle.
module connect_mode_ctrl #(
  parameter int CNT_W      = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic             CLK_i,
  input  logic             RSTN_i,
  input  logic             REQ_EN_i,
  input  logic             ARVALID_i,
  input  logic             ARREADY_i,
  input  logic             RVALID_i,
  input  logic             RREADY_i,
  input  logic             RLAST_i,
  input  logic             AWVALID_i,
  input  logic             AWREADY_i,
  input  logic             WVALID_i,
  input  logic             BVALID_i,
  input  logic             BREADY_i,
  output logic             ENABLE_o,
  output logic             HOLD_o,
  output logic             DONE_o,
  output logic [1:0]       STATE_o,
  output logic [CNT_W-1:0] RD_OUTST_o,
  output logic [CNT_W-1:0] WR_OUTST_o,
  output logic             ERR_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, SETTLE = 2'd2} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t           state, state_nx;
  logic             enable, enable_nx;
  logic             hold, hold_nx;
  logic             done_nx, done;
  logic             target, target_nx;
  logic [3:0]       settle, settle_nx;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;
  logic             err;
  logic [CNT_W:0]   rd_upd, wr_upd;

  logic arhs, rhs, awhs, bhs, drained;

  assign arhs = ARVALID_i & ARREADY_i;
  assign rhs  = RVALID_i & RREADY_i & RLAST_i;
  assign awhs = AWVALID_i & AWREADY_i;
  assign bhs  = BVALID_i & BREADY_i;

  // Fabric is quiet: nothing in flight and nothing being issued this cycle.
  assign drained = (rd_cnt == '0) && (wr_cnt == '0) && !WVALID_i && !arhs && !awhs;

  // Saturating up/down step; MSB of the result flags an over/underflow attempt.
  function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    logic [CNT_W:0] r;
    r = {1'b0, c};
    if (inc && !dec) begin
      if (c == {CNT_W{1'b1}}) r[CNT_W] = 1'b1;
      else                    r[CNT_W-1:0] = c + 1'b1;
    end else if (dec && !inc) begin
      if (c == '0) r[CNT_W] = 1'b1;
      else         r[CNT_W-1:0] = c - 1'b1;
    end
    return r;
  endfunction

  assign rd_upd = cnt_step(rd_cnt, arhs, rhs);
  assign wr_upd = cnt_step(wr_cnt, awhs, bhs);

  // Next-state and registered-output decode for the switch sequencer.
  always_comb begin
    state_nx  = state;
    enable_nx = enable;
    hold_nx   = hold;
    done_nx   = 1'b0;
    target_nx = target;
    settle_nx = settle;
    case (state)
      IDLE: begin
        if (REQ_EN_i != enable) begin
          target_nx = REQ_EN_i;
          state_nx  = DRAIN;
          hold_nx   = 1'b1;
        end
      end
      DRAIN: begin
        if (drained) begin
          enable_nx = target;
          settle_nx = SETTLE_LOAD;
          state_nx  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle == '0) begin
          state_nx = IDLE;
          hold_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          settle_nx = settle - 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        hold_nx  = 1'b0;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge CLK_i or negedge RSTN_i) begin
    if (!RSTN_i) begin
      state  <= IDLE;
      enable <= 1'b0;
      hold   <= 1'b0;
      done   <= 1'b0;
      target <= 1'b0;
      settle <= '0;
    end else begin
      state  <= state_nx;
      enable <= enable_nx;
      hold   <= hold_nx;
      done   <= done_nx;
      target <= target_nx;
      settle <= settle_nx;
    end
  end

  // Outstanding-burst counters run in every state so hold is advisory only.
  always_ff @(posedge CLK_i or negedge RSTN_i) begin
    if (!RSTN_i) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      err    <= 1'b0;
    end else begin
      rd_cnt <= rd_upd[CNT_W-1:0];
      wr_cnt <= wr_upd[CNT_W-1:0];
      err    <= err | rd_upd[CNT_W] | wr_upd[CNT_W];
    end
  end

  assign ENABLE_o   = enable;
  assign HOLD_o     = hold;
  assign DONE_o     = done;
  assign STATE_o    = state;
  assign RD_OUTST_o = rd_cnt;
  assign WR_OUTST_o = wr_cnt;
  assign ERR_o      = err;

endmodule

// File: tb/tb_connect_mode_ctrl.sv
// Directed and randomized checks of connect_mode_ctrl against a behavioural model.
module tb_connect_mode_ctrl;
  localparam int CNT_W  = 2;
  localparam int SETTLE = 2;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic clk = 1'b0, rstn = 1'b0;
  logic req = 1'b0, arv = 1'b0, arr = 1'b0, rv = 1'b0, rr = 1'b0, rl = 1'b0;
  logic awv = 1'b0, awr = 1'b0, wv = 1'b0, bv = 1'b0, br = 1'b0;
  logic en_o, hold_o, done_o, err_o;
  logic [1:0] st_o;
  logic [CNT_W-1:0] rd_o, wr_o;

  int n_pass = 0, n_total = 0;
  // model: phase 0 idle / 1 waiting for quiet / 2 settling
  int m_phase, m_en, m_tgt, m_left, m_done, m_rd, m_wr, m_err;

  always #5 clk = ~clk;

  connect_mode_ctrl #(.CNT_W(CNT_W), .SETTLE_CYC(SETTLE)) dut (
    .CLK_i(clk), .RSTN_i(rstn), .REQ_EN_i(req),
    .ARVALID_i(arv), .ARREADY_i(arr), .RVALID_i(rv), .RREADY_i(rr), .RLAST_i(rl),
    .AWVALID_i(awv), .AWREADY_i(awr), .WVALID_i(wv), .BVALID_i(bv), .BREADY_i(br),
    .ENABLE_o(en_o), .HOLD_o(hold_o), .DONE_o(done_o), .STATE_o(st_o),
    .RD_OUTST_o(rd_o), .WR_OUTST_o(wr_o), .ERR_o(err_o));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_phase = 0; m_en = 0; m_tgt = 0; m_left = 0; m_done = 0;
    m_rd = 0; m_wr = 0; m_err = 0;
  endtask

  // One clock of the specification's rules, using the inputs as sampled at the edge.
  task automatic m_step();
    int a, r, aw, b, quiet, nrd, nwr;
    a  = int'(arv & arr);
    r  = int'(rv & rr & rl);
    aw = int'(awv & awr);
    b  = int'(bv & br);
    quiet = (m_rd == 0 && m_wr == 0 && !wv && a == 0 && aw == 0) ? 1 : 0;
    m_done = 0;
    if (m_phase == 0) begin
      if (int'(req) != m_en) begin m_tgt = int'(req); m_phase = 1; end
    end else if (m_phase == 1) begin
      if (quiet == 1) begin m_en = m_tgt; m_left = SETTLE; m_phase = 2; end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin m_phase = 0; m_done = 1; end
    end
    nrd = m_rd + a - r;
    nwr = m_wr + aw - b;
    if (nrd < 0 || nrd > MAXC) m_err = 1; else m_rd = nrd;
    if (nwr < 0 || nwr > MAXC) m_err = 1; else m_wr = nwr;
  endtask

  task automatic check_all();
    chk("state",  32'(st_o),   32'(m_phase));
    chk("enable", 32'(en_o),   32'(m_en));
    chk("hold",   32'(hold_o), 32'(m_phase != 0));
    chk("done",   32'(done_o), 32'(m_done));
    chk("rd_cnt", 32'(rd_o),   32'(m_rd));
    chk("wr_cnt", 32'(wr_o),   32'(m_wr));
    chk("err",    32'(err_o),  32'(m_err));
  endtask

  task automatic tick();
    if (!rstn) m_reset(); else m_step();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic run_to_idle();
    int k;
    k = 0;
    do begin tick(); k++; end while (st_o != 2'd0 && k < 20);
    chk("idle_reached", 32'(st_o), 32'd0);
  endtask

  initial begin
    int hcnt, dcnt;
    int seq[4];
    m_reset();
    // reset values
    #1;
    check_all();
    tick(); tick();
    rstn = 1'b1;
    tick();

    // idle switch 0->1: state 1,2,2,0, hold for 3 cycles, one done
    req = 1'b1;
    hcnt = 0; dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seq[i] = int'(st_o);
      hcnt += int'(hold_o);
      dcnt += int'(done_o);
      if (i == 1) chk("idle_sw_en", 32'(en_o), 32'd1);
    end
    chk("seq0", 32'(seq[0]), 32'd1);
    chk("seq1", 32'(seq[1]), 32'd2);
    chk("seq2", 32'(seq[2]), 32'd2);
    chk("seq3", 32'(seq[3]), 32'd0);
    chk("hold_cycles", 32'(hcnt), 32'd3);
    chk("done_pulses", 32'(dcnt), 32'd1);

    // drain with three outstanding reads
    arv = 1'b1; arr = 1'b1;
    repeat (3) tick();
    arv = 1'b0; req = 1'b0;
    tick();
    chk("drain_rd3", 32'(rd_o), 32'd3);
    chk("drain_state", 32'(st_o), 32'd1);
    rv = 1'b1; rr = 1'b1; rl = 1'b1;
    repeat (3) tick();
    chk("drain_still", 32'(st_o), 32'd1);
    chk("drain_en_kept", 32'(en_o), 32'd1);
    rv = 1'b0;
    tick();
    chk("drain_en_flip", 32'(en_o), 32'd0);
    run_to_idle();

    // simultaneous read issue and completion
    arv = 1'b1;
    tick();
    rv = 1'b1;
    tick();
    chk("simul_rd1", 32'(rd_o), 32'd1);
    arv = 1'b0;
    tick();
    rv = 1'b0;
    // write accepted while hold is high delays the switch
    req = 1'b1;
    tick();
    awv = 1'b1; awr = 1'b1;
    tick();
    awv = 1'b0;
    tick(); tick();
    chk("aw_hold_wr", 32'(wr_o), 32'd1);
    chk("aw_hold_state", 32'(st_o), 32'd1);
    bv = 1'b1; br = 1'b1;
    tick();
    bv = 1'b0;
    tick();
    chk("aw_hold_en", 32'(en_o), 32'd1);
    run_to_idle();

    // request bouncing during drain
    req = 1'b0;
    tick();
    run_to_idle();
    wv = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    tick(); tick();
    wv = 1'b0;
    dcnt = 0;
    repeat (12) begin tick(); dcnt += int'(done_o); end
    chk("bounce_dones", 32'(dcnt), 32'd2);
    chk("bounce_en", 32'(en_o), 32'd0);

    // reset mid-settle with enable already high
    req = 1'b1;
    tick(); tick();
    chk("pre_rst_en", 32'(en_o), 32'd1);
    #2 rstn = 1'b0;
    #1;
    m_reset();
    chk("rst_en", 32'(en_o), 32'd0);
    chk("rst_hold", 32'(hold_o), 32'd0);
    chk("rst_state", 32'(st_o), 32'd0);
    check_all();
    tick();
    rstn = 1'b1;
    repeat (6) tick();
    chk("rst_restart_en", 32'(en_o), 32'd1);

    // saturation at CNT_W=2
    arv = 1'b1; arr = 1'b1;
    repeat (4) tick();
    arv = 1'b0;
    chk("sat_rd", 32'(rd_o), 32'd3);
    chk("sat_err", 32'(err_o), 32'd1);
    rv = 1'b1; rr = 1'b1; rl = 1'b1;
    repeat (4) tick();
    rv = 1'b0;
    chk("under_rd", 32'(rd_o), 32'd0);
    chk("under_err", 32'(err_o), 32'd1);

    // randomized traffic, requests and occasional reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) req = ~req;
      arv = 1'($urandom); arr = 1'($urandom);
      rv  = 1'($urandom); rr  = 1'($urandom); rl = 1'($urandom);
      awv = 1'($urandom); awr = 1'($urandom);
      bv  = 1'($urandom); br  = 1'($urandom);
      wv  = ($urandom_range(7) == 0);
      rstn = ($urandom_range(499) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
